// File: rtl/rv32i_operand_fetch.sv
// rtl/rv32i_operand_fetch.sv - register file read client with writeback bypass and stall coherence
module rv32i_operand_fetch #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [4:0]       i_in_rs1_addr,
  input  logic [4:0]       i_in_rs2_addr,
  input  logic [TAG_W-1:0] i_in_tag,
  output logic [4:0]       o_rf_rs1_addr,
  output logic [4:0]       o_rf_rs2_addr,
  input  logic [XLEN-1:0]  i_rf_rs1,
  input  logic [XLEN-1:0]  i_rf_rs2,
  input  logic             i_wb_wr,
  input  logic [4:0]       i_wb_rd_addr,
  input  logic [XLEN-1:0]  i_wb_rd,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [XLEN-1:0]  o_out_rs1,
  output logic [XLEN-1:0]  o_out_rs2,
  output logic [TAG_W-1:0] o_out_tag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t           r_state;
  logic [4:0]       r_rs1_addr;
  logic [4:0]       r_rs2_addr;
  logic [TAG_W-1:0] r_tag;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_rs1;
  logic [XLEN-1:0]  r_out_rs2;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_acc;
  logic             w_wb_hit1;
  logic             w_wb_hit2;
  logic [XLEN-1:0]  w_sel_rs1;
  logic [XLEN-1:0]  w_sel_rs2;

  assign o_in_ready = !i_flush &&
                      ((r_state == IDLE) || ((r_state == VALID) && i_out_ready));
  assign w_acc      = i_in_valid && o_in_ready;

  // The file registers its address every edge, so hold it steady unless a new instruction enters.
  assign o_rf_rs1_addr = w_acc ? i_in_rs1_addr : r_rs1_addr;
  assign o_rf_rs2_addr = w_acc ? i_in_rs2_addr : r_rs2_addr;

  assign w_wb_hit1 = i_wb_wr && (i_wb_rd_addr == r_rs1_addr) && (r_rs1_addr != 5'd0);
  assign w_wb_hit2 = i_wb_wr && (i_wb_rd_addr == r_rs2_addr) && (r_rs2_addr != 5'd0);

  always_comb begin
    w_sel_rs1 = i_rf_rs1;
    if (r_rs1_addr == 5'd0)
      w_sel_rs1 = '0;
    else if (w_wb_hit1)
      w_sel_rs1 = i_wb_rd;
  end

  always_comb begin
    w_sel_rs2 = i_rf_rs2;
    if (r_rs2_addr == 5'd0)
      w_sel_rs2 = '0;
    else if (w_wb_hit2)
      w_sel_rs2 = i_wb_rd;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_tag       <= '0;
      r_out_valid <= 1'b0;
      r_out_rs1   <= '0;
      r_out_rs2   <= '0;
      r_out_tag   <= '0;
    end else if (i_flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      if (w_acc) begin
        r_rs1_addr <= i_in_rs1_addr;
        r_rs2_addr <= i_in_rs2_addr;
        r_tag      <= i_in_tag;
      end
      case (r_state)
        IDLE: begin
          if (w_acc)
            r_state <= READ;
        end
        READ: begin
          r_state     <= VALID;
          r_out_valid <= 1'b1;
          r_out_rs1   <= w_sel_rs1;
          r_out_rs2   <= w_sel_rs2;
          r_out_tag   <= r_tag;
        end
        VALID: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= i_in_valid ? READ : IDLE;
          end else begin
            // Stalled: track writes to the held sources so the operands never go stale.
            if (w_wb_hit1)
              r_out_rs1 <= i_wb_rd;
            if (w_wb_hit2)
              r_out_rs2 <= i_wb_rd;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_rs1   = r_out_rs1;
  assign o_out_rs2   = r_out_rs2;
  assign o_out_tag   = r_out_tag;

endmodule

// File: tb/tb_rv32i_operand_fetch.sv
// tb/tb_rv32i_operand_fetch.sv - directed bench with a registered-address register file model
module tb_rv32i_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr;
  logic [4:0]  in_rs2_addr;
  logic [31:0] in_tag;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;
  logic        wb_wr;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1;
  logic [31:0] out_rs2;
  logic [31:0] out_tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32i_operand_fetch #(.XLEN(32), .TAG_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_rs1_addr(in_rs1_addr), .i_in_rs2_addr(in_rs2_addr), .i_in_tag(in_tag),
    .o_rf_rs1_addr(rf_rs1_addr), .o_rf_rs2_addr(rf_rs2_addr),
    .i_rf_rs1(rf_rs1), .i_rf_rs2(rf_rs2),
    .i_wb_wr(wb_wr), .i_wb_rd_addr(wb_rd_addr), .i_wb_rd(wb_rd),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_rs1(out_rs1), .o_out_rs2(out_rs2), .o_out_tag(out_tag)
  );

  // Register file model: stores every write (x0 included), addresses registered on clk.
  logic [31:0] rf_mem [32];
  logic [4:0]  rf_a1, rf_a2;
  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    rf_a1 = 5'd0;
    rf_a2 = 5'd0;
  end
  always @(posedge clk) begin
    if (wb_wr) rf_mem[wb_rd_addr] <= wb_rd;
    rf_a1 <= rf_rs1_addr;
    rf_a2 <= rf_rs2_addr;
  end
  assign rf_rs1 = rf_mem[rf_a1];
  assign rf_rs2 = rf_mem[rf_a2];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_wr = 1'b1; wb_rd_addr = a; wb_rd = d;
    tick();
    wb_wr = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] t);
    in_valid = 1'b1; in_rs1_addr = a1; in_rs2_addr = a2; in_tag = t;
    #1;
    check("issue_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] next_tag;
  logic [31:0] exp_tag;
  logic [31:0] old_tag;
  logic        s_acc, s_out;
  int          n_out;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_rs1_addr = '0; in_rs2_addr = '0;
    in_tag = '0; wb_wr = 1'b0; wb_rd_addr = '0; wb_rd = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_rs1", out_rs1, 32'd0);
    check("rst_out_tag", out_tag, 32'd0);
    check("rst_rf_addr", {22'd0, rf_rs1_addr, rf_rs2_addr}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: preloaded x5, rs2=x0
    wb_write(5'd5, 32'h0000_1234);
    in_valid = 1'b1; in_rs1_addr = 5'd5; in_rs2_addr = 5'd0; in_tag = 32'h100;
    #1;
    check("t1_rf_addr_bypass", {27'd0, rf_rs1_addr}, 32'd5);
    tick();
    in_valid = 1'b0;
    check("t1_valid_after_1clk", {31'd0, out_valid}, 32'd0);
    check("t1_in_ready_read", {31'd0, in_ready}, 32'd0);
    check("t1_rf_addr_held", {27'd0, rf_rs1_addr}, 32'd5);
    tick();
    check("t1_valid_after_2clk", {31'd0, out_valid}, 32'd1);
    check("t1_rs1", out_rs1, 32'h0000_1234);
    check("t1_rs2", out_rs2, 32'h0);
    check("t1_tag", out_tag, 32'h100);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_drop", {31'd0, out_valid}, 32'd0);

    // 2: x0 written but reads as zero
    wb_write(5'd0, 32'hFFFF_FFFF);
    issue(5'd0, 5'd0, 32'h200);
    tick();
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_rs1", out_rs1, 32'h0);
    check("t2_rs2", out_rs2, 32'h0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 3: writeback bypass during READ
    issue(5'd7, 5'd5, 32'h300);
    wb_wr = 1'b1; wb_rd_addr = 5'd7; wb_rd = 32'hDEAD_BEEF;
    tick();
    wb_wr = 1'b0;
    check("t3_rs1_bypass", out_rs1, 32'hDEAD_BEEF);
    check("t3_rs2", out_rs2, 32'h0000_1234);
    check("t3_tag", out_tag, 32'h300);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 4: stall coherence, both sources same register
    issue(5'd3, 5'd3, 32'h400);
    tick();
    check("t4_rs1_init", out_rs1, 32'h0);
    wb_write(5'd3, 32'hA5A5_A5A5);
    check("t4_rs1_upd", out_rs1, 32'hA5A5_A5A5);
    check("t4_rs2_upd", out_rs2, 32'hA5A5_A5A5);
    check("t4_tag_stable", out_tag, 32'h400);
    check("t4_valid_held", {31'd0, out_valid}, 32'd1);
    wb_write(5'd9, 32'h1111_2222);
    check("t4_rs1_no_hit", out_rs1, 32'hA5A5_A5A5);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("t4_accepted_once", {31'd0, out_valid}, 32'd0);
    tick();
    check("t4_stays_idle", {31'd0, out_valid}, 32'd0);

    // 5: back-to-back streaming
    next_tag = 32'h500; n_out = 0;
    in_valid = 1'b1; in_rs1_addr = 5'd5; in_rs2_addr = 5'd0; in_tag = next_tag;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      s_acc = in_valid & in_ready;
      s_out = out_valid & out_ready;
      old_tag = out_tag;
      if (s_acc) exp_q.push_back(next_tag);
      if (s_out) begin
        n_out++;
        exp_tag = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check("t5_tag_order", old_tag, exp_tag);
        check("t5_rs1", out_rs1, 32'h0000_1234);
      end
      tick();
      if (s_acc) begin
        next_tag = next_tag + 32'd1;
        in_tag = next_tag;
      end
    end
    in_valid = 1'b0;
    check("t5_pulse_count", n_out, 32'd5);
    tick(); tick();
    check("t5_drained", {31'd0, out_valid}, 32'd0);
    exp_q.delete();

    // 6: flush in VALID beats out_ready/in_valid
    out_ready = 1'b0;
    issue(5'd5, 5'd0, 32'h600);
    tick();
    check("t6_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1; in_valid = 1'b1; in_tag = 32'h601; flush = 1'b1;
    #1;
    check("t6_in_ready_flush", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("t6_valid_dropped", {31'd0, out_valid}, 32'd0);
    check("t6_idle_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("t6_no_accept", {31'd0, out_valid}, 32'd0);

    // Reset mid-READ
    out_ready = 1'b0;
    issue(5'd5, 5'd5, 32'h700);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_rs1", out_rs1, 32'h0);
    check("rst_mid_tag", out_tag, 32'h0);
    check("rst_mid_rf_addr", {27'd0, rf_rs1_addr}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("rst_mid_no_resume", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
